rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 99 +++++++++
 tb/tb_rr_arbiter_8.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with hold limit and post-grant gap
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [7:0] hcnt, hcnt_nx;
  logic [2:0] idx_nx;
  logic       valid_nx;
  logic       timeout_nx;
  logic [2:0] pick;
  logic [2:0] cand;
  logic       normal_exit;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick = 3'd0;
    cand = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) pick = cand;
    end
  end

  assign normal_exit = rel || !req[grant_idx];

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    hcnt_nx    = hcnt;
    idx_nx     = grant_idx;
    valid_nx   = grant_valid;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nx   = pick;
          valid_nx = 1'b1;
          hcnt_nx  = 8'd1;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (normal_exit || hcnt == MAX_HOLD_C) begin
          // A release or request drop takes precedence over expiry.
          timeout_nx = !normal_exit;
          idx_nx     = 3'd0;
          valid_nx   = 1'b0;
          ptr_nx     = grant_idx + 3'd1;
          hcnt_nx    = 8'd0;
          state_nx   = GAP;
        end else begin
          hcnt_nx = hcnt + 8'd1;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      hcnt        <= 8'd0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      grant       <= 8'd0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      hcnt        <= hcnt_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      grant       <= valid_nx ? (8'b1 << idx_nx) : 8'd0;
      timeout     <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed vector bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arbiter_8 #(.MAX_HOLD(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] req;
    logic       rel;
    logic [7:0] g;
    logic [2:0] idx;
    logic       v;
    logic       t;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    rel   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (grant_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int cnt;

    // req, rel, grant, idx, valid, timeout after the edge
    vecs[0]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{8'h81, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[5]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{8'h81, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[12] = '{8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[15] = '{8'h28, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[16] = '{8'h28, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[17] = '{8'h28, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[18] = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[19] = '{8'h28, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 8'h00;
    rel   = 1'b0;
    #3;
    chk("reset_outputs", {19'd0, grant, grant_idx, grant_valid, timeout}, 32'd0);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      req = vecs[i].req;
      rel = vecs[i].rel;
      tick();
      chk($sformatf("vec%0d", i), {19'd0, grant, grant_idx, grant_valid, timeout},
          {19'd0, vecs[i].g, vecs[i].idx, vecs[i].v, vecs[i].t});
    end

    // Full rotation with wrap from owner 7 back to 0.
    do_reset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      wait_valid(ok);
      chk($sformatf("rot_valid%0d", n), {31'd0, ok}, 32'd1);
      chk($sformatf("rot_idx%0d", n), {29'd0, grant_idx}, 32'(n % 8));
      chk($sformatf("rot_onehot%0d", n), {24'd0, grant}, 32'(8'h01 << (n % 8)));
      rel = 1'b1;
      tick();
      rel = 1'b0;
      chk($sformatf("rot_drop%0d", n), {31'd0, grant_valid}, 32'd0);
    end

    // Hold expiry: visible for exactly 15 cycles, timeout as it drops.
    do_reset();
    req = 8'h04;
    wait_valid(ok);
    chk("exp_first", {31'd0, ok}, 32'd1);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (grant == 8'h04) cnt++;
      else break;
    end
    chk("exp_len", 32'(cnt), 32'd15);
    chk("exp_timeout", {31'd0, timeout}, 32'd1);
    chk("exp_grant0", {24'd0, grant}, 32'd0);
    tick();
    chk("exp_timeout_pulse", {31'd0, timeout}, 32'd0);
    wait_valid(ok);
    chk("exp_regrant", {31'd0, ok}, 32'd1);
    chk("exp_regrant_idx", {29'd0, grant_idx}, 32'd2);

    // Release on the expiry cycle beats the timeout.
    do_reset();
    req = 8'h04;
    wait_valid(ok);
    chk("relx_first", {31'd0, ok}, 32'd1);
    for (int k = 1; k < 15; k++) tick();
    chk("relx_held", {24'd0, grant}, 32'h04);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("relx_grant", {24'd0, grant}, 32'd0);
    chk("relx_timeout", {31'd0, timeout}, 32'd0);

    // Asynchronous reset mid-grant, then restart from ptr 0.
    do_reset();
    req = 8'h10;
    tick();
    chk("arst_pre", {24'd0, grant}, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {19'd0, grant, grant_idx, grant_valid, timeout}, 32'd0);
    req = 8'h30;
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_restart", {24'd0, grant}, 32'h10);
    chk("arst_idx", {29'd0, grant_idx}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
